// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and the ROM.
// The fetcher drives request and address; memory answers with ack and data.
interface instr_fetch_if #(
    parameter int PC_W = 10
) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: FETCH -> DECODE -> RESOLVE loop that owns the PC,
// presents each word to the decoder and resolves jump/branch/sequential next PC.
module instr_fetch #(
    parameter int              PC_W     = 10,
    parameter int              BR_W     = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_if.master     imem,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic [PC_W-1:0]   pc,
    input  logic              jmpEnable,
    input  logic              branchEnable,
    input  logic [PC_W-1:0]   jmpDir,
    input  logic [BR_W-1:0]   branchDir,
    input  logic              stall,
    output logic [15:0]       retired
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            fetch_req;
    logic            load_instr;
    logic            commit;
    logic [PC_W-1:0] branch_offset;
    logic [PC_W-1:0] pc_next;

    // Reset gates the request combinationally so the reset cycle never shows req high.
    assign imem.imem_req  = fetch_req & ~reset;
    assign imem.imem_addr = pc;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        fetch_req  = 1'b0;
        load_instr = 1'b0;
        commit     = 1'b0;
        unique case (state)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (imem.imem_ack) begin
                    load_instr = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (!stall) begin
                    commit     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Branch offset is relative to the branch's own address; overflow wraps modulo 2^PC_W.
    assign branch_offset = PC_W'($signed(branchDir));

    always_comb begin
        if (jmpEnable) begin
            pc_next = jmpDir;
        end else if (branchEnable) begin
            pc_next = pc + branch_offset;
        end else begin
            pc_next = pc + PC_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            retired     <= 16'h0000;
        end else begin
            instr_valid <= load_instr;
            if (load_instr) begin
                instr <= imem.imem_data;
            end
            if (commit) begin
                pc      <= pc_next;
                retired <= retired + 16'd1;
            end
        end
    end

    a_state_legal: assert property (@(posedge clk) disable iff (reset)
        state inside {S_FETCH, S_DECODE, S_RESOLVE});

    a_valid_pulse: assert property (@(posedge clk) disable iff (reset)
        instr_valid |-> state == S_DECODE);

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch: acts as instruction memory and decoder,
// and compares against a transaction-level model of PC flow and retire count.
module tb_instr_fetch;

    localparam int PC_W  = 10;
    localparam int BR_W  = 6;
    localparam int DEPTH = 1 << PC_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       instr;
    logic              instr_valid;
    logic [PC_W-1:0]   pc;
    logic              jmpEnable;
    logic              branchEnable;
    logic [PC_W-1:0]   jmpDir;
    logic [BR_W-1:0]   branchDir;
    logic              stall;
    logic [15:0]       retired;

    instr_fetch_if #(.PC_W(PC_W)) bus ();

    instr_fetch #(.PC_W(PC_W), .BR_W(BR_W), .RESET_PC('0)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (bus),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .jmpEnable    (jmpEnable),
        .branchEnable (branchEnable),
        .jmpDir       (jmpDir),
        .branchDir    (branchDir),
        .stall        (stall),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [DEPTH];
    int          m_pc;
    int          m_ret;
    logic [15:0] m_instr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC: plain integer arithmetic with modulo wrap.
    function automatic int model_next_pc(input int cur, input bit jmp, input bit br,
                                         input logic [PC_W-1:0] jd, input logic [BR_W-1:0] bd);
        int off;
        off = $signed(bd);
        if (jmp) return int'(jd);
        if (br)  return (((cur + off) % DEPTH) + DEPTH) % DEPTH;
        return (cur + 1) % DEPTH;
    endfunction

    // Entered and left in FETCH, shortly after a clock edge.
    task automatic do_instr(input int ack_delay, input int stall_cycles, input bit jmp, input bit br,
                            input logic [PC_W-1:0] jd, input logic [BR_W-1:0] bd, input bit spurious);
        for (int i = 0; i < ack_delay; i++) begin
            bus.imem_ack  = 1'b0;
            bus.imem_data = 16'($urandom);
            #1;
            check("wait_req",   32'(bus.imem_req),  32'd1);
            check("wait_addr",  32'(bus.imem_addr), 32'(m_pc));
            check("wait_instr", 32'(instr),         32'(m_instr));
            check("wait_valid", 32'(instr_valid),   32'd0);
            tick();
        end
        check("fetch_req",  32'(bus.imem_req),  32'd1);
        check("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        bus.imem_ack  = 1'b1;
        bus.imem_data = mem[m_pc];
        tick();

        // DECODE
        m_instr       = mem[m_pc];
        bus.imem_ack  = spurious;
        bus.imem_data = 16'($urandom);
        check("dec_valid", 32'(instr_valid),  32'd1);
        check("dec_instr", 32'(instr),        32'(m_instr));
        check("dec_pc",    32'(pc),           32'(m_pc));
        check("dec_req",   32'(bus.imem_req), 32'd0);
        tick();

        // RESOLVE
        jmpEnable    = jmp;
        branchEnable = br;
        jmpDir       = jd;
        branchDir    = bd;
        stall        = (stall_cycles > 0);
        #1;
        check("res_valid", 32'(instr_valid),  32'd0);
        check("res_req",   32'(bus.imem_req), 32'd0);
        for (int s = 0; s < stall_cycles; s++) begin
            tick();
            check("stall_pc",      32'(pc),           32'(m_pc));
            check("stall_instr",   32'(instr),        32'(m_instr));
            check("stall_retired", 32'(retired),      32'(m_ret));
            check("stall_req",     32'(bus.imem_req), 32'd0);
            if (s == stall_cycles - 1) stall = 1'b0;
        end
        tick();

        m_pc  = model_next_pc(m_pc, jmp, br, jd, bd);
        m_ret = (m_ret + 1) % 65536;
        bus.imem_ack = 1'b0;
        jmpEnable    = 1'b0;
        branchEnable = 1'b0;
        stall        = 1'b0;
        #1;
        check("commit_pc",      32'(pc),           32'(m_pc));
        check("commit_retired", 32'(retired),      32'(m_ret));
        check("commit_req",     32'(bus.imem_req), 32'd1);
        check("commit_instr",   32'(instr),        32'(m_instr));
    endtask

    task automatic do_random(input int n);
        for (int k = 0; k < n; k++) begin
            do_instr(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 2) == 0),
                     PC_W'($urandom), BR_W'($urandom),
                     $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] = 16'($urandom);
        reset         = 1'b1;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'h0000;
        jmpEnable     = 1'b0;
        branchEnable  = 1'b0;
        jmpDir        = '0;
        branchDir     = '0;
        stall         = 1'b0;
        m_pc          = 0;
        m_ret         = 0;
        m_instr       = 16'h0000;

        tick();
        tick();
        check("rst_req",     32'(bus.imem_req), 32'd0);
        check("rst_pc",      32'(pc),           32'd0);
        check("rst_instr",   32'(instr),        32'd0);
        check("rst_valid",   32'(instr_valid),  32'd0);
        check("rst_retired", 32'(retired),      32'd0);
        reset = 1'b0;
        #1;
        check("first_req",  32'(bus.imem_req),  32'd1);
        check("first_addr", 32'(bus.imem_addr), 32'd0);

        // Sequential flow, then a 3-cycle ack wait at address 5.
        for (int k = 0; k < 5; k++) do_instr(0, 0, 0, 0, '0, '0, 0);
        do_instr(3, 0, 0, 0, '0, '0, 0);
        do_instr(0, 0, 0, 0, '0, '0, 1);
        check("pc_at_7", 32'(pc), 32'd7);
        // Jump beats branch.
        do_instr(0, 0, 1, 1, 10'h3F0, 6'h02, 0);
        check("jump_addr", 32'(bus.imem_addr), 32'h3F0);
        do_instr(0, 0, 0, 1, '0, 6'h1F, 0);
        check("br_wrap_up", 32'(bus.imem_addr), 32'h00F);
        do_instr(0, 0, 1, 0, 10'h001, '0, 0);
        do_instr(0, 0, 0, 1, '0, 6'h3E, 0);
        check("br_wrap_down", 32'(bus.imem_addr), 32'h3FF);
        do_instr(0, 4, 0, 0, '0, '0, 1);
        check("pc_wrap_inc", 32'(bus.imem_addr), 32'h000);

        do_random(300);

        // Reset during FETCH with ack high: reset must win.
        do_instr(0, 0, 1, 0, 10'h123, '0, 0);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 16'hBEEF;
        reset         = 1'b1;
        #1;
        check("midrst_req", 32'(bus.imem_req), 32'd0);
        tick();
        check("midrst_instr",   32'(instr),        32'd0);
        check("midrst_pc",      32'(pc),           32'd0);
        check("midrst_valid",   32'(instr_valid),  32'd0);
        check("midrst_retired", 32'(retired),      32'd0);
        check("midrst_req2",    32'(bus.imem_req), 32'd0);
        reset        = 1'b0;
        bus.imem_ack = 1'b0;
        m_pc         = 0;
        m_ret        = 0;
        m_instr      = 16'h0000;
        #1;
        check("postrst_req",  32'(bus.imem_req),  32'd1);
        check("postrst_addr", 32'(bus.imem_addr), 32'd0);

        do_random(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
